top: RTL and testbench



---
 rtl/top_if.sv | 9 +
 rtl/top.sv | 84 ++++++++
 tb/tb_top.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/top_if.sv
// top_if: processor start-address input and architectural debug outputs
interface top_if;
   logic [31:0] pc;
   logic [31:0] pc_out;
   logic [31:0] instr_out;
   logic [31:0] s0_out;
   modport master (output pc, input pc_out, instr_out, s0_out);
   modport slave (input pc, output pc_out, instr_out, s0_out);
endinterface

// File: rtl/top.sv
// top: single-cycle MIPS32-subset core with 16-word instruction ROM and 32x32 register file
module regfile (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic [31:0] zero,
   output logic [31:0] s0
);
   logic [31:0] r [32];
   // clear everything on reset; r0 is never written so it stays 0
   always_ff @(posedge clk)
      if (!rst_n) r <= '{default: '0};
      else if (we && wa != 5'd0) r[wa] <= wd;
   assign rd1 = ra1 == 5'd0 ? '0 : r[ra1];
   assign rd2 = ra2 == 5'd0 ? '0 : r[ra2];
   assign zero = r[0];
   assign s0 = r[16];
endmodule

module top (
   input logic clk,
   input logic rst_n,
   top_if.slave bus
);
   localparam logic [31:0] ROM [16] = '{
      32'h20100005, 32'h20110003, 32'h02119020, 32'h02119822,
      32'h02114024, 32'h02114825, 32'h0230502A, 32'h12100001,
      32'h201400FF, 32'h20140001, 32'h3C100001, 32'h36100002,
      32'h20000007, 32'h0800000A, 32'h00000000, 32'h00000000
   };
   logic [31:0] pc_q, instr, pc4, npc, sext, rd1, rd2, wd;
   logic [5:0]  op, funct;
   logic [4:0]  wa;
   logic        we;
   logic [31:0] s0;
   logic [31:0] zero_unused;
   assign instr = |pc_q[31:6] ? 32'h0 : ROM[pc_q[5:2]];
   assign op = instr[31:26];
   assign funct = instr[5:0];
   assign pc4 = pc_q + 32'd4;
   assign sext = {{16{instr[15]}}, instr[15:0]};
   regfile r1 (
      .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
      .ra1(instr[25:21]), .ra2(instr[20:16]), .rd1(rd1), .rd2(rd2),
      .zero(zero_unused), .s0(s0)
   );
   // decode and execute the fetched instruction; unknown encodings fall through as nops
   always_comb begin
      we = 1'b0;
      wa = instr[20:16];
      wd = '0;
      npc = pc4;
      case (op)
         6'h00: begin
            wa = instr[15:11];
            we = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
            wd = funct == 6'h20 ? rd1 + rd2 :
                 funct == 6'h22 ? rd1 - rd2 :
                 funct == 6'h24 ? rd1 & rd2 :
                 funct == 6'h25 ? rd1 | rd2 :
                 {31'h0, $signed(rd1) < $signed(rd2)};
         end
         6'h08: begin we = 1'b1; wd = rd1 + sext; end
         6'h0D: begin we = 1'b1; wd = rd1 | {16'h0, instr[15:0]}; end
         6'h0F: begin we = 1'b1; wd = {instr[15:0], 16'h0}; end
         6'h04: npc = rd1 == rd2 ? pc4 + {sext[29:0], 2'b00} : pc4;
         6'h02: npc = {pc4[31:28], instr[25:0], 2'b00};
         default: ;
      endcase
   end
   // program counter: load start address in reset, otherwise follow next-pc
   always_ff @(posedge clk)
      if (!rst_n) pc_q <= bus.pc;
      else pc_q <= npc;
   assign bus.pc_out = pc_q;
   assign bus.instr_out = instr;
   assign bus.s0_out = s0;
endmodule

// File: tb/tb_top.sv
// tb_top: randomized scoreboard bench comparing the core against an ISA-level model
module tb_top;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   top_if bus ();
   top dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] s0;
      logic [31:0][31:0] rf;
   } exp_t;
   exp_t q[$];
   int total = 0;
   int bad = 0;
   logic [31:0] mrom [16];
   logic [31:0] mr [32];
   logic [31:0] mpc;

   task automatic check(input string n, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", n, got, want, $time);
      end
   endtask

   function automatic logic [31:0] fetch(input logic [31:0] a);
      return (a >= 32'h40) ? 32'h0 : mrom[a[5:2]];
   endfunction

   // architectural interpreter: registers as an array, pc as a number
   task automatic model_step(input logic r, input logic [31:0] pin);
      logic [31:0] ins, a, b, res, nxt, simm;
      int dest;
      if (!r) begin
         mpc = pin;
         foreach (mr[i]) mr[i] = 32'h0;
         return;
      end
      ins = fetch(mpc);
      a = mr[ins[25:21]];
      b = mr[ins[20:16]];
      simm = 32'($signed(ins[15:0]));
      nxt = mpc + 4;
      dest = 0;
      res = 0;
      case (ins[31:26])
         6'h00: begin
            dest = ins[15:11];
            case (ins[5:0])
               6'h20: res = a + b;
               6'h22: res = a - b;
               6'h24: res = a & b;
               6'h25: res = a | b;
               6'h2A: res = ($signed(a) < $signed(b)) ? 1 : 0;
               default: dest = 0;
            endcase
         end
         6'h08: begin dest = ins[20:16]; res = a + simm; end
         6'h0D: begin dest = ins[20:16]; res = a | (ins & 32'hFFFF); end
         6'h0F: begin dest = ins[20:16]; res = (ins & 32'hFFFF) << 16; end
         6'h04: if (a == b) nxt = mpc + 4 + (simm << 2);
         6'h02: nxt = ((mpc + 4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
         default: ;
      endcase
      if (dest != 0) mr[dest] = res;
      mpc = nxt;
   endtask

   task automatic cyc(input logic r, input logic [31:0] p);
      exp_t e;
      @(negedge clk);
      rst_n = r;
      bus.pc = p;
      @(posedge clk);
      model_step(r, p);
      e.pc = mpc;
      e.instr = fetch(mpc);
      e.s0 = mr[16];
      for (int i = 0; i < 32; i++) e.rf[i] = mr[i];
      q.push_back(e);
      #2;
   endtask

   // monitor: every cycle the core presents state, compare with the oldest expectation
   initial begin
      exp_t e;
      int nbad;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("pc_out", bus.pc_out, e.pc);
            check("instr_out", bus.instr_out, e.instr);
            check("s0_out", bus.s0_out, e.s0);
            check("r1.s0", dut.r1.s0, e.s0);
            check("r1.zero", dut.r1.zero, 32'h0);
            nbad = 0;
            for (int i = 0; i < 32; i++)
               if (dut.r1.r[i] !== e.rf[i]) begin
                  nbad++;
                  $display("FAIL reg%0d got=%h want=%h t=%0t", i, dut.r1.r[i], e.rf[i], $time);
               end
            total++;
            if (nbad != 0) bad++;
         end
      end
   end

   initial begin
      logic [31:0] st;
      int n;
      mrom = '{32'h20100005, 32'h20110003, 32'h02119020, 32'h02119822,
               32'h02114024, 32'h02114825, 32'h0230502A, 32'h12100001,
               32'h201400FF, 32'h20140001, 32'h3C100001, 32'h36100002,
               32'h20000007, 32'h0800000A, 32'h00000000, 32'h00000000};
      bus.pc = 32'h0;
      cyc(0, 32'h28);
      check("rst_pc", bus.pc_out, 32'h28);
      check("rst_s0", bus.s0_out, 32'h0);
      cyc(1, $urandom);
      check("lui_s0", bus.s0_out, 32'h0001_0000);
      check("lui_pc", bus.pc_out, 32'h2C);
      cyc(1, $urandom);
      check("ori_s0", bus.s0_out, 32'h0001_0002);
      cyc(1, $urandom);
      check("zero_w", dut.r1.zero, 32'h0);
      cyc(1, $urandom);
      check("j_pc", bus.pc_out, 32'h28);
      cyc(1, $urandom);
      check("loop_s0", bus.s0_out, 32'h0001_0000);
      cyc(0, 32'h0);
      for (int i = 0; i < 7; i++) cyc(1, $urandom);
      check("alu_s0", dut.r1.r[16], 32'd5);
      check("alu_s1", dut.r1.r[17], 32'd3);
      check("alu_s2", dut.r1.r[18], 32'd8);
      check("alu_s3", dut.r1.r[19], 32'd2);
      check("alu_t0", dut.r1.r[8], 32'd1);
      check("alu_t1", dut.r1.r[9], 32'd7);
      check("alu_t2", dut.r1.r[10], 32'd1);
      cyc(1, $urandom);
      check("beq_pc", bus.pc_out, 32'h24);
      cyc(1, $urandom);
      check("s4", dut.r1.r[20], 32'd1);
      cyc(1, $urandom);
      cyc(0, 32'h28);
      check("mid_rst_pc", bus.pc_out, 32'h28);
      check("mid_rst_s4", dut.r1.r[20], 32'h0);
      cyc(1, $urandom);
      check("mid_rst_s0", bus.s0_out, 32'h0001_0000);
      cyc(0, 32'h40);
      for (int i = 0; i < 4; i++) cyc(1, $urandom);
      check("oor_pc", bus.pc_out, 32'h50);
      check("oor_instr", bus.instr_out, 32'h0);
      for (int s = 0; s < 40; s++) begin
         case ($urandom_range(0, 4))
            0: st = 32'h0;
            1: st = 32'h28;
            2: st = 32'h40;
            3: st = $urandom_range(0, 19) * 4;
            default: st = $urandom & 32'hFFFF_FFFC;
         endcase
         cyc(0, st);
         n = $urandom_range(1, 25);
         for (int i = 0; i < n; i++)
            if ($urandom_range(0, 15) == 0) cyc(0, ($urandom_range(0, 1) == 1) ? 32'h28 : $urandom_range(0, 19) * 4);
            else cyc(1, $urandom);
      end
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      check("drain", q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
